// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared widths and FSM state type for the adder scheduler
package adder_sched_pkg;
  localparam int OP_W = 10;
  localparam int SUM_W = 11;
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;
endpackage

// File: rtl/adder_10bit.sv
// adder_10bit: unsigned 10-bit adder with carry-out in the top sum bit
module adder_10bit
  import adder_sched_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic [SUM_W-1:0] sum
);
  assign sum = SUM_W'(a) + SUM_W'(b);
endmodule

// File: rtl/adder_scheduler.sv
// adder_scheduler: round-robin sharing of one 10-bit adder among N_REQ requesters
module adder_scheduler
  import adder_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*OP_W-1:0]  req_a,
  input  logic [N_REQ*OP_W-1:0]  req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [SUM_W-1:0]       rsp_sum,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_ready,
  output logic                   busy
);
  state_e state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, gnt_id, idx;
  logic [OP_W-1:0] a_q, a_d, b_q, b_d;
  logic [SUM_W-1:0] sum_q, sum_d, add_sum;
  logic [OP_W-1:0] a_arr [N_REQ];
  logic [OP_W-1:0] b_arr [N_REQ];
  logic grant;
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*OP_W +: OP_W];
    assign b_arr[i] = req_b[i*OP_W +: OP_W];
  end
  adder_10bit u_add (.a(a_q), .b(b_q), .sum(add_sum));
  // Round-robin pick: scan backwards from ptr so the nearest valid requester is assigned last
  always_comb begin
    gnt_id = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (req_valid[idx]) gnt_id = idx;
    end
  end
  assign grant     = !rst && state_q == IDLE && |req_valid;
  assign req_ready = grant ? N_REQ'(1) << gnt_id : '0;
  assign rsp_valid = state_q == HOLD;
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign busy      = state_q != IDLE;
  // Next state: latch winner in IDLE, capture adder result in CALC, wait for consumer in HOLD
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    unique case (state_q)
      IDLE: if (grant) begin
        state_d = CALC;
        ptr_d   = gnt_id == ID_W'(N_REQ - 1) ? '0 : gnt_id + 1'b1;
        id_d    = gnt_id;
        a_d     = a_arr[gnt_id];
        b_d     = b_arr[gnt_id];
      end
      CALC: begin
        sum_d   = add_sum;
        state_d = HOLD;
      end
      HOLD: state_d = rsp_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end
endmodule

// File: tb/tb_adder_scheduler.sv
// tb_adder_scheduler: directed self-checking bench for adder_scheduler
module tb_adder_scheduler;
  logic        clk, rst;
  logic [3:0]  req_valid, req_ready;
  logic [39:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, busy;
  logic [10:0] rsp_sum;
  logic [1:0]  rsp_id;
  int checks = 0;
  int failures = 0;
  int ord [5] = '{0, 1, 2, 3, 0};
  adder_scheduler #(.N_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(input int i, input int a, input int b);
    req_a[i*10 +: 10] = 10'(a);
    req_b[i*10 +: 10] = 10'(b);
  endtask
  // Grants must be one-hot or zero and never happen while busy
  always @(negedge clk) if (rst === 1'b0) begin
    checks++;
    assert ($onehot0(req_ready) && !(busy && |req_ready)) else begin
      failures++;
      $error("FAIL grant_monitor req_ready=%b busy=%b", req_ready, busy);
    end
  end
  initial begin
    rst = 1;
    req_valid = 4'b1111;
    rsp_ready = 0;
    req_a = '0;
    req_b = '0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_id", rsp_id, 0);
    step();
    step();
    rst = 0;
    req_valid = 0;
    step();
    chk("idle_busy", busy, 0);
    set_op(0, 5, 7);
    req_valid = 4'b0001;
    rsp_ready = 1;
    #1;
    chk("t1_ready", req_ready, 1);
    step();
    req_valid = 0;
    chk("t1_calc_busy", busy, 1);
    chk("t1_calc_valid", rsp_valid, 0);
    chk("t1_calc_ready", req_ready, 0);
    step();
    chk("t1_valid", rsp_valid, 1);
    chk("t1_sum", rsp_sum, 12);
    chk("t1_id", rsp_id, 0);
    step();
    chk("t1_done_valid", rsp_valid, 0);
    chk("t1_done_busy", busy, 0);
    rsp_ready = 0;
    set_op(2, 1023, 1023);
    req_valid = 4'b0100;
    #1;
    chk("t2_ready", req_ready, 4);
    step();
    req_valid = 4'b1111;
    #1;
    chk("t2_calc_ready", req_ready, 0);
    step();
    chk("t2_valid", rsp_valid, 1);
    chk("t2_sum", rsp_sum, 2046);
    chk("t2_carry", rsp_sum[10], 1);
    chk("t2_id", rsp_id, 2);
    repeat (5) begin
      step();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_sum", rsp_sum, 2046);
      chk("bp_id", rsp_id, 2);
      chk("bp_ready", req_ready, 0);
    end
    rsp_ready = 1;
    step();
    chk("bp_release_busy", busy, 0);
    chk("rr_ptr3_ready", req_ready, 8);
    req_valid = 0;
    #1;
    chk("withdraw_ready", req_ready, 0);
    step();
    chk("withdraw_busy", busy, 0);
    rst = 1;
    #2;
    chk("async_rst_busy", busy, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) set_op(i, 100 * (i + 1), i + 1);
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      chk("rr_ready", req_ready, 32'(1) << ord[n]);
      step();
      chk("rr_calc_ready", req_ready, 0);
      step();
      chk("rr_valid", rsp_valid, 1);
      chk("rr_id", rsp_id, ord[n]);
      chk("rr_sum", rsp_sum, 101 * (ord[n] + 1));
      step();
    end
    req_valid = 4'b0010;
    #1;
    chk("t4_ready", req_ready, 2);
    step();
    req_valid = 0;
    #2;
    rst = 1;
    #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_valid", rsp_valid, 0);
    chk("t4_rst_id", rsp_id, 0);
    chk("t4_rst_sum", rsp_sum, 0);
    rst = 0;
    repeat (3) begin
      step();
      chk("t4_no_rsp", rsp_valid, 0);
    end
    set_op(0, 300, 45);
    req_valid = 4'b0011;
    #1;
    chk("t4_first_grant", req_ready, 1);
    step();
    req_valid = 0;
    step();
    chk("t4_valid", rsp_valid, 1);
    chk("t4_id", rsp_id, 0);
    chk("t4_sum", rsp_sum, 345);
    step();
    chk("t4_done_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
